// File: rtl/analysis_pkg.sv
// Shared definitions for the analysis-path frame arbiter.
//   DEFAULT_DATA_W    : default sample width (windowed buffer output)
//   DEFAULT_FRAME_LEN : default beats per analysis frame (power of two)
//   ch_idx_t          : channel index (0 = left, 1 = right)
//   arb_state_t       : arbiter FSM state
package analysis_pkg;

   localparam int unsigned DEFAULT_DATA_W    = 24;
   localparam int unsigned DEFAULT_FRAME_LEN = 1024;

   typedef logic [0:0] ch_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/analysis_frame_arbiter.sv
// Shares one windowed-FFT analysis path between two sample-buffer streams.
// Whole frames of FRAME_LEN beats are granted round-robin and never split.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   ch_en[1:0]              : per-channel enable, only looked at when arbitrating
//   in0_* / in1_*           : per-channel valid/ready sample streams
//   out_data/valid/ready    : FFT input stream
//   out_last                : final beat of the current frame
//   out_ch                  : channel owning the current beat
//   frame_done[1:0]         : one-cycle pulse per channel after its last beat
//   frame_cnt0/frame_cnt1   : completed-frame counters, wrap silently
module analysis_frame_arbiter
   import analysis_pkg::*;
#(
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        ch_en,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_valid,
   output logic              in1_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              out_ch,
   output logic [1:0]        frame_done,
   output logic [CNT_W-1:0]  frame_cnt0,
   output logic [CNT_W-1:0]  frame_cnt1
);

   localparam int unsigned       BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

   arb_state_t        state_q;
   logic [BEAT_W-1:0] beat_cnt_q;
   ch_idx_t           last_ch_q;
   logic [1:0]        frame_done_q;
   logic [CNT_W-1:0]  frame_cnt0_q;
   logic [CNT_W-1:0]  frame_cnt1_q;

   logic [1:0] req;
   ch_idx_t    gnt_ch;
   logic       beat;
   logic       at_last;

   // Two-way priority pick: with both requesting, the preferred channel wins.
   function automatic arb_state_t arb_pick(input logic [1:0] reqs, input ch_idx_t prefer);
      arb_state_t pick;
      if (reqs == 2'b11) begin
         pick = (prefer == 1'b1) ? GRANT1 : GRANT0;
      end else if (reqs[0]) begin
         pick = GRANT0;
      end else if (reqs[1]) begin
         pick = GRANT1;
      end else begin
         pick = IDLE;
      end
      return pick;
   endfunction

   assign req    = ch_en & {in1_valid, in0_valid};
   assign gnt_ch = ch_idx_t'(state_q == GRANT1);

   // Zero-latency datapath steered by the registered grant.
   always_comb begin
      out_data  = '0;
      out_valid = 1'b0;
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      unique case (state_q)
         GRANT0: begin
            out_data  = in0_data;
            out_valid = in0_valid;
            in0_ready = out_ready;
         end
         GRANT1: begin
            out_data  = in1_data;
            out_valid = in1_valid;
            in1_ready = out_ready;
         end
         default: ;
      endcase
   end

   assign beat       = out_valid && out_ready;
   assign at_last    = (beat_cnt_q == LAST_BEAT);
   assign out_last   = at_last && out_valid;
   assign out_ch     = gnt_ch;
   assign frame_done = frame_done_q;
   assign frame_cnt0 = frame_cnt0_q;
   assign frame_cnt1 = frame_cnt1_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         last_ch_q    <= 1'b1;  // ch0 wins the first tie
         frame_done_q <= '0;
         frame_cnt0_q <= '0;
         frame_cnt1_q <= '0;
      end else begin
         frame_done_q <= '0;
         unique case (state_q)
            IDLE: begin
               state_q <= arb_pick(req, ~last_ch_q);
            end
            GRANT0, GRANT1: begin
               // Grant is held until the last beat regardless of ch_en or valid gaps.
               if (beat) begin
                  if (at_last) begin
                     beat_cnt_q           <= '0;
                     last_ch_q            <= gnt_ch;
                     frame_done_q[gnt_ch] <= 1'b1;
                     if (gnt_ch == 1'b0) begin
                        frame_cnt0_q <= frame_cnt0_q + CNT_W'(1);
                     end else begin
                        frame_cnt1_q <= frame_cnt1_q + CNT_W'(1);
                     end
                     // Re-arbitrate now, other channel preferred, so no bubble.
                     state_q <= arb_pick(req, ~gnt_ch);
                  end else begin
                     beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_analysis_frame_arbiter.sv
// Scoreboard bench for analysis_frame_arbiter: stimulus pushes expected frames,
// a negedge monitor pops and compares every transferred beat.
module tb_analysis_frame_arbiter;

   localparam int unsigned DATA_W    = 24;
   localparam int unsigned FRAME_LEN = 1024;
   localparam int unsigned CNT_W     = 16;

   logic              clk;
   logic              reset_n;
   logic [1:0]        ch_en;
   logic [DATA_W-1:0] in0_data;
   logic              in0_valid;
   logic              in0_ready;
   logic [DATA_W-1:0] in1_data;
   logic              in1_valid;
   logic              in1_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              out_ch;
   logic [1:0]        frame_done;
   logic [CNT_W-1:0]  frame_cnt0;
   logic [CNT_W-1:0]  frame_cnt1;

   analysis_frame_arbiter #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ch_en      (ch_en),
      .in0_data   (in0_data),
      .in0_valid  (in0_valid),
      .in0_ready  (in0_ready),
      .in1_data   (in1_data),
      .in1_valid  (in1_valid),
      .in1_ready  (in1_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .out_ch     (out_ch),
      .frame_done (frame_done),
      .frame_cnt0 (frame_cnt0),
      .frame_cnt1 (frame_cnt1)
   );

   typedef struct packed {
      logic              ch;
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t       exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          beats_total = 0;
   int          done_cnt[2] = '{0, 0};
   int          in1_viol = 0;
   bit          chk_in1_off = 0;
   bit          hs0 = 0;
   bit          hs1 = 0;
   int unsigned seq0 = 0;
   int unsigned seq1 = 0;
   int unsigned exp_seq[2] = '{0, 0};
   int          exp_cnt[2] = '{0, 0};
   bit          v0_en = 1;
   bit          v1_en = 1;
   bit          gap_mode = 0;
   bit          bp_mode = 0;

   function automatic logic [DATA_W-1:0] src_data(input logic ch, input int unsigned seq);
      return {ch, seq[DATA_W-2:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic ch);
      for (int i = 0; i < int'(FRAME_LEN); i++) begin
         beat_t b;
         b.ch   = ch;
         b.last = (i == int'(FRAME_LEN) - 1);
         b.data = src_data(ch, exp_seq[ch] + i);
         exp_q.push_back(b);
      end
      exp_seq[ch] += FRAME_LEN;
      exp_cnt[ch]++;
   endtask

   task automatic wait_beats(input int target, input string name);
      int c = 0;
      while (beats_total < target && c < 20000) begin
         @(posedge clk);
         #2;
         c++;
      end
      check(name, 64'(beats_total >= target), 1);
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      while (exp_q.size() != 0 && c < 20000) begin
         @(posedge clk);
         #2;
         c++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sources: data advances only after a beat was accepted.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (hs0) seq0++;
         if (hs1) seq1++;
         in0_data  = src_data(1'b0, seq0);
         in1_data  = src_data(1'b1, seq1);
         in0_valid = gap_mode ? ($urandom_range(0, 3) != 0) : v0_en;
         in1_valid = v1_en;
         out_ready = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         hs0 = 0;
         hs1 = 0;
      end else begin
         hs0 = in0_valid && in0_ready;
         hs1 = in1_valid && in1_ready;
         if (frame_done[0]) done_cnt[0]++;
         if (frame_done[1]) done_cnt[1]++;
         if (chk_in1_off && in1_ready) in1_viol++;
         if (out_valid && out_ready) begin
            beats_total++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {out_ch, out_last, out_data}, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat", {out_ch, out_last, out_data}, e);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int d0;
      int d1;
      int cyc;
      int unsigned start;

      reset_n   = 1'b0;
      ch_en     = 2'b00;
      out_ready = 1'b1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in0_ready", in0_ready, 0);
      check("rst_in1_ready", in1_ready, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_cnt0", frame_cnt0, 0);
      check("rst_frame_cnt1", frame_cnt1, 0);
      reset_n = 1'b1;

      // 1: ch0 only, continuous.
      base = beats_total;
      d0 = done_cnt[0];
      d1 = done_cnt[1];
      chk_in1_off = 1;
      in1_viol = 0;
      push_frame(1'b0);
      ch_en = 2'b01;
      wait_beats(base + 1, "t1_start");
      ch_en = 2'b00;
      wait_drain("t1_drain");
      repeat (3) @(posedge clk);
      #2;
      check("t1_beats", beats_total - base, FRAME_LEN);
      check("t1_done0", done_cnt[0] - d0, 1);
      check("t1_done1", done_cnt[1] - d1, 0);
      check("t1_frame_cnt0", frame_cnt0, exp_cnt[0]);

      // Both disabled: no grants even with valids high.
      base = beats_total;
      repeat (20) @(posedge clk);
      #2;
      check("dis_beats", beats_total - base, 0);
      check("dis_in0_ready", in0_ready, 0);
      check("dis_in1_ready", in1_ready, 0);
      check("dis_out_valid", out_valid, 0);

      // 3: valid gaps and back-pressure on a ch0 frame.
      base = beats_total;
      gap_mode = 1;
      bp_mode = 1;
      push_frame(1'b0);
      ch_en = 2'b01;
      wait_beats(base + 1, "t3_start");
      ch_en = 2'b00;
      wait_drain("t3_drain");
      gap_mode = 0;
      bp_mode = 0;
      repeat (3) @(posedge clk);
      #2;
      check("t3_beats", beats_total - base, FRAME_LEN);
      check("t3_frame_cnt0", frame_cnt0, exp_cnt[0]);
      check("t3_in1_ready_low", in1_viol, 0);
      chk_in1_off = 0;

      // 4: ch_en[0] drops mid-frame; frame completes, ch1 served after.
      base = beats_total;
      d1 = done_cnt[1];
      push_frame(1'b0);
      push_frame(1'b1);
      push_frame(1'b1);
      ch_en = 2'b01;
      wait_beats(base + 1, "t4_start");
      ch_en = 2'b11;
      wait_beats(base + 500, "t4_beat500");
      ch_en = 2'b10;
      wait_beats(base + 2 * int'(FRAME_LEN) + 1, "t4_ch1_second");
      ch_en = 2'b00;
      wait_drain("t4_drain");
      repeat (3) @(posedge clk);
      #2;
      check("t4_beats", beats_total - base, 3 * FRAME_LEN);
      check("t4_frame_cnt0", frame_cnt0, exp_cnt[0]);
      check("t4_frame_cnt1", frame_cnt1, exp_cnt[1]);
      check("t4_done1", done_cnt[1] - d1, 2);

      // 2: both continuous from reset; frames back to back.
      reset_n = 1'b0;
      exp_q.delete();
      exp_cnt = '{0, 0};
      ch_en = 2'b11;
      repeat (2) @(posedge clk);
      #2;
      push_frame(1'b0);
      push_frame(1'b1);
      push_frame(1'b0);
      base = beats_total;
      cyc = 0;
      reset_n = 1'b1;
      while (beats_total - base < 3 * int'(FRAME_LEN) && cyc < 5000) begin
         @(posedge clk);
         cyc++;
         #2;
         if (beats_total - base >= 2100) ch_en = 2'b00;
      end
      check("t2_cycles", cyc, 3 * FRAME_LEN + 1);
      wait_drain("t2_drain");
      repeat (3) @(posedge clk);
      #2;
      check("t2_frame_cnt0", frame_cnt0, exp_cnt[0]);
      check("t2_frame_cnt1", frame_cnt1, exp_cnt[1]);

      // 5: reset at beat 300 of a ch0 frame.
      base = beats_total;
      start = exp_seq[0];
      push_frame(1'b0);
      ch_en = 2'b01;
      wait_beats(base + 300, "t5_beat300");
      reset_n = 1'b0;
      #1;
      check("t5_async_out_valid", out_valid, 0);
      check("t5_async_in0_ready", in0_ready, 0);
      check("t5_async_out_last", out_last, 0);
      check("t5_async_frame_cnt0", frame_cnt0, 0);
      check("t5_async_frame_done", frame_done, 0);
      exp_q.delete();
      exp_seq[0] = start + 300;
      exp_cnt = '{0, 0};
      ch_en = 2'b11;
      @(posedge clk);
      #2;
      push_frame(1'b0);
      base = beats_total;
      reset_n = 1'b1;
      wait_beats(base + 1, "t5_regrant");
      ch_en = 2'b00;
      wait_drain("t5_drain");
      repeat (3) @(posedge clk);
      #2;
      check("t5_beats", beats_total - base, FRAME_LEN);
      check("t5_frame_cnt0", frame_cnt0, exp_cnt[0]);
      check("t5_frame_cnt1", frame_cnt1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
